// File: rtl/dp_accum_pkg.sv
// Shared types and helpers for the dot-product accumulate/requant stage.
// Also used by the pooling stage.
package dp_accum_pkg;

  localparam int ACC_W = 32;
  localparam int OUT_W = 8;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};

  typedef enum logic {
    ACCUM = 1'b0,
    OUT   = 1'b1
  } acc_state_t;

  typedef struct packed {
    logic signed [ACC_W-1:0] sum;
    logic                    sat;
  } sat_sum_t;

  // The addend is non-negative, so only positive overflow can occur; clamp it to ACC_MAX.
  function automatic sat_sum_t sat_add(input logic signed [ACC_W-1:0] acc,
                                       input logic [ACC_W-1:0]        zext_in);
    sat_sum_t        res;
    logic [ACC_W:0]  wide;
    wide = {acc[ACC_W-1], acc} + {1'b0, zext_in};
    if (!wide[ACC_W] && wide[ACC_W-1]) begin
      res.sum = ACC_MAX;
      res.sat = 1'b1;
    end else begin
      res.sum = wide[ACC_W-1:0];
      res.sat = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/dot_product_accum_if.sv
// Partial-sum input stream, per-group config and activation output stream
// of the accumulate stage.
interface dot_product_accum_if #(
  parameter int IN_W    = 17,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 5
);
  logic                    in_valid;
  logic                    in_ready;
  logic [IN_W-1:0]         in_data;
  logic                    in_last;
  logic signed [ACC_W-1:0] cfg_bias;
  logic [SHIFT_W-1:0]      cfg_shift;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_W-1:0]        out_data;
  logic                    out_sat;
  logic                    err_len;

  modport master (
    output in_valid, in_data, in_last, cfg_bias, cfg_shift, out_ready,
    input  in_ready, out_valid, out_data, out_sat, err_len
  );

  modport slave (
    input  in_valid, in_data, in_last, cfg_bias, cfg_shift, out_ready,
    output in_ready, out_valid, out_data, out_sat, err_len
  );
endinterface

// File: rtl/dp_requant.sv
// Combinational requantisation: ReLU, arithmetic right shift and clamp to
// an unsigned OUT_W-bit activation.
module dp_requant #(
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 5
) (
  input  logic signed [ACC_W-1:0] s,
  input  logic [SHIFT_W-1:0]      shift,
  output logic [OUT_W-1:0]        data,
  output logic                    sat
);

  localparam logic [ACC_W-1:0] OUT_MAX = ACC_W'({OUT_W{1'b1}});

  logic [ACC_W-1:0] r_s;

  // Negative sums clip to zero; shifted values above the output range clamp high.
  always_comb begin
    data = '0;
    sat  = 1'b0;
    r_s  = $unsigned(s) >> shift;
    if (s[ACC_W-1]) begin
      data = '0;
      sat  = 1'b0;
    end else if (r_s > OUT_MAX) begin
      data = '1;
      sat  = 1'b1;
    end else begin
      data = r_s[OUT_W-1:0];
      sat  = 1'b0;
    end
  end

endmodule

// File: rtl/dot_product_accum.sv
// Accumulates a group of partial dot products into one neuron, then emits a
// requantised 8-bit activation over a valid/ready handshake.
module dot_product_accum
  import dp_accum_pkg::*;
#(
  parameter int IN_W      = 17,
  parameter int SHIFT_W   = 5,
  parameter int MAX_BEATS = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  dot_product_accum_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  acc_state_t              state_r;
  logic signed [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0]        beat_cnt_r;
  logic                    first_r;
  logic [SHIFT_W-1:0]      shift_r;
  logic                    sat_acc_r;
  logic                    in_ready_r;
  logic                    out_valid_r;
  logic [OUT_W-1:0]        out_data_r;
  logic                    out_sat_r;
  logic                    err_len_r;

  logic signed [ACC_W-1:0] base_s;
  logic [ACC_W-1:0]        zext_s;
  logic [SHIFT_W-1:0]      shift_s;
  sat_sum_t                sum_s;
  logic signed [ACC_W-1:0] sum_val_s;
  logic [OUT_W-1:0]        rq_data_s;
  logic                    rq_sat_s;
  logic                    take_s;

  // On a group's first beat the live config replaces the accumulator and latched shift.
  always_comb begin
    base_s  = acc_r;
    shift_s = shift_r;
    if (first_r) begin
      base_s  = bus.cfg_bias;
      shift_s = bus.cfg_shift;
    end else begin
      base_s  = acc_r;
      shift_s = shift_r;
    end
    zext_s    = {{(ACC_W-IN_W){1'b0}}, bus.in_data};
    sum_s     = sat_add(base_s, zext_s);
    sum_val_s = sum_s.sum;
    take_s    = bus.in_valid & in_ready_r;
  end

  dp_requant #(
    .ACC_W  (ACC_W),
    .OUT_W  (OUT_W),
    .SHIFT_W(SHIFT_W)
  ) u_requant (
    .s    (sum_val_s),
    .shift(shift_s),
    .data (rq_data_s),
    .sat  (rq_sat_s)
  );

  // Group FSM, accumulator, beat counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ACCUM;
      acc_r       <= '0;
      beat_cnt_r  <= '0;
      first_r     <= 1'b1;
      shift_r     <= '0;
      sat_acc_r   <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sat_r   <= 1'b0;
      err_len_r   <= 1'b0;
    end else begin
      case (state_r)
        ACCUM: begin
          in_ready_r <= 1'b1;
          if (take_s) begin
            first_r   <= 1'b0;
            acc_r     <= sum_s.sum;
            sat_acc_r <= sat_acc_r | sum_s.sat;
            if (first_r) begin
              shift_r <= bus.cfg_shift;
            end
            if (bus.in_last) begin
              state_r     <= OUT;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
              out_data_r  <= rq_data_s;
              out_sat_r   <= rq_sat_s | sat_acc_r | sum_s.sat;
              first_r     <= 1'b1;
              beat_cnt_r  <= '0;
            end else if (beat_cnt_r == CNT_W'(MAX_BEATS)) begin
              // Overlong group: flag it and keep accumulating with the count parked.
              err_len_r <= 1'b1;
            end else begin
              beat_cnt_r <= beat_cnt_r + CNT_W'(1);
            end
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            state_r     <= ACCUM;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            acc_r       <= '0;
            sat_acc_r   <= 1'b0;
          end
        end
        default: begin
          state_r     <= ACCUM;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_sat   = out_sat_r;
  assign bus.err_len   = err_len_r;

endmodule
